// File: rtl/arashi_read_responder.sv
// Cache-side read responder: one outstanding request slot per thread, consumes arbiter grants,
// issues the memory read and returns data tagged with the thread index after RD_LAT cycles.
module arashi_read_responder #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned MEM_WIDTH        = 10,
    parameter int unsigned THREAD_NUM_WIDTH = 2,
    parameter int unsigned RD_LAT           = 2,
    localparam int unsigned THREAD_NUM      = 1 << THREAD_NUM_WIDTH
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [THREAD_NUM-1:0]           req_valid,
    input  logic [THREAD_NUM*MEM_WIDTH-1:0] req_addr,
    output logic [THREAD_NUM-1:0]           req_ready,
    output logic [THREAD_NUM-1:0]           avail,
    input  logic [THREAD_NUM_WIDTH-1:0]     toread,
    input  logic                            rcache,
    output logic                            mem_ren,
    output logic [MEM_WIDTH-1:0]            mem_raddr,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic                            rsp_valid,
    output logic [THREAD_NUM_WIDTH-1:0]     rsp_thread,
    output logic [DATA_WIDTH-1:0]           rsp_data
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPending  = 2'd1,
        StInflight = 2'd2
    } slot_state_e;

    slot_state_e                 slot_q [THREAD_NUM];
    slot_state_e                 slot_d [THREAD_NUM];
    logic [MEM_WIDTH-1:0]        addr_q [THREAD_NUM];
    logic [MEM_WIDTH-1:0]        addr_d [THREAD_NUM];

    logic                        grant;
    logic                        tail_valid;
    logic [THREAD_NUM_WIDTH-1:0] tail_thread;

    logic                        ren_q;
    logic [MEM_WIDTH-1:0]        raddr_q;
    logic [THREAD_NUM_WIDTH-1:0] ren_thread_q;

    logic [RD_LAT-1:0]           pipe_valid_q;
    logic [THREAD_NUM_WIDTH-1:0] pipe_thread_q [RD_LAT];

    logic                        rsp_valid_q;
    logic [THREAD_NUM_WIDTH-1:0] rsp_thread_q;
    logic [DATA_WIDTH-1:0]       rsp_data_q;

    // A grant only counts when the selected slot is still pending; re-grants are dropped.
    assign grant       = rcache && (slot_q[toread] == StPending);
    assign tail_valid  = pipe_valid_q[RD_LAT-1];
    assign tail_thread = pipe_thread_q[RD_LAT-1];

    always_comb begin
        for (int t = 0; t < THREAD_NUM; t++) begin
            slot_d[t] = slot_q[t];
            addr_d[t] = addr_q[t];
            case (slot_q[t])
                StIdle: begin
                    if (req_valid[t]) begin
                        slot_d[t] = StPending;
                        addr_d[t] = req_addr[t*MEM_WIDTH +: MEM_WIDTH];
                    end
                end
                StPending: begin
                    if (grant && (toread == THREAD_NUM_WIDTH'(t))) begin
                        slot_d[t] = StInflight;
                    end
                end
                StInflight: begin
                    // Freed on the edge that raises rsp_valid, so it is idle in the response cycle.
                    if (tail_valid && (tail_thread == THREAD_NUM_WIDTH'(t))) begin
                        slot_d[t] = StIdle;
                    end
                end
                default: slot_d[t] = StIdle;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        avail     = '0;
        for (int t = 0; t < THREAD_NUM; t++) begin
            req_ready[t] = (slot_q[t] == StIdle);
            avail[t]     = (slot_q[t] == StPending);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int t = 0; t < THREAD_NUM; t++) begin
                slot_q[t] <= StIdle;
                addr_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < THREAD_NUM; t++) begin
                slot_q[t] <= slot_d[t];
                addr_q[t] <= addr_d[t];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ren_q        <= 1'b0;
            raddr_q      <= '0;
            ren_thread_q <= '0;
        end else begin
            ren_q        <= grant;
            ren_thread_q <= toread;
            if (grant) begin
                raddr_q <= addr_q[toread];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pipe_valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_thread_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0]  <= ren_q;
            pipe_thread_q[0] <= ren_thread_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid_q[i]  <= pipe_valid_q[i-1];
                pipe_thread_q[i] <= pipe_thread_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_valid_q  <= 1'b0;
            rsp_thread_q <= '0;
            rsp_data_q   <= '0;
        end else begin
            rsp_valid_q <= tail_valid;
            if (tail_valid) begin
                rsp_thread_q <= tail_thread;
                rsp_data_q   <= mem_rdata;
            end
        end
    end

    assign mem_ren    = ren_q;
    assign mem_raddr  = raddr_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_thread = rsp_thread_q;
    assign rsp_data   = rsp_data_q;

endmodule
